// File: rtl/mem_pkg.sv
// mem_pkg: shared types and sizes for the data-memory responder
package mem_pkg;
  typedef enum logic {IDLE, BEAT2} state_t;
  localparam int DEFAULT_ADDR_W = 12;
  localparam int WORD_W = 16;
endpackage

// File: rtl/dm_word_ram.sv
// dm_word_ram: single-port synchronous 16-bit RAM with registered read data
module dm_word_ram import mem_pkg::*; #(
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);
  logic [WORD_W-1:0] mem [2**ADDR_W];
  // read-before-write port; contents are never cleared
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: memory-stage data port serving 16/32-bit accesses from a 16-bit RAM
module data_mem_responder import mem_pkg::*; #(
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic        clk,
  input  logic        i_reset,
  input  logic        i_memRead,
  input  logic        i_memWrite,
  input  logic        i_en32,
  input  logic [31:0] i_address,
  input  logic [31:0] i_wdata,
  output logic        o_ready,
  output logic        o_rsp_valid,
  output logic [31:0] o_rdata,
  output logic        o_err,
  output logic        o_busy
);
  state_t state, state_nxt;
  logic accept, both, ram_we, wr_q, err_q, rsp_rd, rsp_wide;
  logic [ADDR_W-1:0] addr_q, ram_addr;
  logic [WORD_W-1:0] wlo_q, hi_q, ram_wdata, ram_rdata;
  logic [31:0] rdata_q;
  assign o_ready = (state == IDLE) & ~i_reset;
  assign o_busy = (state == BEAT2);
  assign accept = o_ready & (i_memRead | i_memWrite);
  assign both = i_memRead & i_memWrite;
  // next state and RAM port steering: beat 2 runs purely off captured values
  always_comb begin
    state_nxt = (accept & i_en32) ? BEAT2 : IDLE;
    ram_we = o_busy ? (wr_q & ~i_reset) : (accept & i_memWrite);
    ram_addr = o_busy ? addr_q + ADDR_W'(1) : i_address[ADDR_W-1:0];
    ram_wdata = o_busy ? wlo_q : (i_en32 ? i_wdata[31:16] : i_wdata[15:0]);
    o_rdata = (o_rsp_valid & rsp_rd) ? (rsp_wide ? {hi_q, ram_rdata} : {16'h0000, ram_rdata}) : rdata_q;
  end
  // state register
  always_ff @(posedge clk) state <= i_reset ? IDLE : state_nxt;
  // capture request on acceptance; grab the high read word while the low one is fetched
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q <= i_address[ADDR_W-1:0];
      wlo_q <= i_wdata[15:0];
      wr_q <= i_memWrite;
      err_q <= both;
    end
    if (o_busy) hi_q <= ram_rdata;
  end
  // response pulse generation and read-data hold register
  always_ff @(posedge clk) begin
    if (i_reset) begin
      o_rsp_valid <= 1'b0;
      o_err <= 1'b0;
      rsp_rd <= 1'b0;
      rsp_wide <= 1'b0;
      rdata_q <= '0;
    end else begin
      o_rsp_valid <= (accept & ~i_en32) | o_busy;
      o_err <= (accept & ~i_en32) ? both : (o_busy & err_q);
      rsp_rd <= accept ? ~i_memWrite : ~wr_q;
      rsp_wide <= o_busy;
      if (o_rsp_valid & rsp_rd) rdata_q <= o_rdata;
    end
  end
  dm_word_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk(clk),
    .we(ram_we),
    .addr(ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );
endmodule
